// File: rtl/dm_cache_ctrl_if.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl_if
// Bundles the CPU request port, the main-memory port and the statistics
// counters of the direct-mapped cache controller.
//
//   CPU side : cpu_req, cpu_we, cpu_addr[9:0], cpu_wdata[31:0]   (to cache)
//              cpu_rdata[31:0], cpu_ready, cpu_hit               (from cache)
//   Memory   : mem_read, mem_lock, mem_addr[9:0], mem_wdata[127:0] (from cache)
//              mem_rdata[127:0]                                    (to cache)
//   Stats    : hit_count, miss_count [CNT_W-1:0]                   (from cache)
//
// Modports:
//   slave  - the cache controller itself
//   master - the environment (CPU + memory + statistics reader)
// -----------------------------------------------------------------------------
interface dm_cache_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             cpu_req;
    logic             cpu_we;
    logic [9:0]       cpu_addr;
    logic [31:0]      cpu_wdata;
    logic [31:0]      cpu_rdata;
    logic             cpu_ready;
    logic             cpu_hit;
    logic             mem_read;
    logic             mem_lock;
    logic [9:0]       mem_addr;
    logic [127:0]     mem_wdata;
    logic [127:0]     mem_rdata;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] miss_count;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        output cpu_rdata, cpu_ready, cpu_hit,
        output mem_read, mem_lock, mem_addr, mem_wdata,
        output hit_count, miss_count
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
        input  cpu_rdata, cpu_ready, cpu_hit,
        input  mem_read, mem_lock, mem_addr, mem_wdata,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// dm_cache_ctrl
// Direct-mapped, write-through, no-write-allocate cache controller sitting
// between a single-word CPU port and a 128-bit block memory port.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - dm_cache_ctrl_if.slave: CPU request/response, memory port
//            (isMemRead/isLock/address/writeData/readData) and hit/miss counters
//
// Address split: offset = addr[1:0], index = addr[IDX_W+1:2],
// tag = addr[9:IDX_W+2]. Block word 0 lives in [127:96], word 3 in [31:0].
//
// Every output is a flop loaded from the *next* state, so each output is
// aligned with the state it belongs to: cpu_ready is high exactly during
// RESP and mem_lock is low exactly during FILL/WRITE.
// -----------------------------------------------------------------------------
module dm_cache_ctrl #(
    parameter int NUM_LINES   = 4,
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    dm_cache_ctrl_if.slave   bus
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 8 - IDX_W;
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COMPARE = 3'd1,
        ST_FILL    = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RESP    = 3'd4
    } state_e;

    // Word 0 of a block is the most significant 32 bits.
    function automatic logic [31:0] sel_word(input logic [127:0] blk,
                                             input logic [1:0]   off);
        logic [31:0] w;
        case (off)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            2'd3:    w = blk[31:0];
            default: w = 32'd0;
        endcase
        return w;
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] blk,
                                              input logic [1:0]   off,
                                              input logic [31:0]  w);
        logic [127:0] b;
        b = blk;
        case (off)
            2'd0:    b[127:96] = w;
            2'd1:    b[95:64]  = w;
            2'd2:    b[63:32]  = w;
            2'd3:    b[31:0]   = w;
            default: b = blk;
        endcase
        return b;
    endfunction

    // Control state and latched request
    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic [9:0]             addr_q, addr_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [LAT_W-1:0]       lat_q, lat_d;

    // Line array
    logic [NUM_LINES-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [TAG_W-1:0]       tag_d  [NUM_LINES];
    logic [127:0]           data_q [NUM_LINES];
    logic [127:0]           data_d [NUM_LINES];

    // Registered outputs
    logic [31:0]            cpu_rdata_q, cpu_rdata_d;
    logic                   cpu_ready_q, cpu_ready_d;
    logic                   cpu_hit_q, cpu_hit_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_lock_q, mem_lock_d;
    logic [9:0]             mem_addr_q, mem_addr_d;
    logic [127:0]           mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]       hit_count_q, hit_count_d;
    logic [CNT_W-1:0]       miss_count_q, miss_count_d;

    // Decoded fields of the latched request
    logic [1:0]             offset_s;
    logic [IDX_W-1:0]       index_s;
    logic [TAG_W-1:0]       tag_s;
    logic                   hit_s;
    logic [127:0]           line_s;

    assign offset_s = addr_q[1:0];
    assign index_s  = addr_q[IDX_W+1:2];
    assign tag_s    = addr_q[9:IDX_W+2];
    assign hit_s    = valid_q[index_s] && (tag_q[index_s] == tag_s);
    assign line_s   = data_q[index_s];

    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.cpu_ready  = cpu_ready_q;
    assign bus.cpu_hit    = cpu_hit_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_lock   = mem_lock_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

    // Next-state, line-array update and next-output computation
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_d        = lat_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = data_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_hit_d    = cpu_hit_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    state_d = ST_COMPARE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_COMPARE: begin
                cpu_hit_d = hit_s;
                if (hit_s) begin
                    if (hit_count_q != {CNT_W{1'b1}}) begin
                        hit_count_d = hit_count_q + CNT_W'(1);
                    end else begin
                        hit_count_d = hit_count_q;
                    end
                end else begin
                    if (miss_count_q != {CNT_W{1'b1}}) begin
                        miss_count_d = miss_count_q + CNT_W'(1);
                    end else begin
                        miss_count_d = miss_count_q;
                    end
                end

                if (we_q) begin
                    // Write-through: always go to memory; only a hit touches the line.
                    lat_d   = LAT_LOAD;
                    state_d = ST_WRITE;
                    if (hit_s) begin
                        data_d[index_s] = put_word(line_s, offset_s, wdata_q);
                    end else begin
                        data_d[index_s] = line_s;
                    end
                end else if (hit_s) begin
                    cpu_rdata_d = sel_word(line_s, offset_s);
                    state_d     = ST_RESP;
                end else begin
                    lat_d   = LAT_LOAD;
                    state_d = ST_FILL;
                end
            end

            ST_FILL: begin
                if (lat_q == {LAT_W{1'b0}}) begin
                    // Conflicting line is replaced unconditionally (never dirty).
                    data_d[index_s]  = bus.mem_rdata;
                    tag_d[index_s]   = tag_s;
                    valid_d[index_s] = 1'b1;
                    cpu_rdata_d      = sel_word(bus.mem_rdata, offset_s);
                    state_d          = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            ST_WRITE: begin
                if (lat_q == {LAT_W{1'b0}}) begin
                    cpu_rdata_d = 32'd0;
                    state_d     = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered so they line up with it.
        cpu_ready_d = (state_d == ST_RESP);
        mem_lock_d  = !((state_d == ST_FILL) || (state_d == ST_WRITE));
        mem_read_d  = (state_d != ST_WRITE);

        if (state_d == ST_FILL) begin
            mem_addr_d = {addr_q[9:2], 2'b00};
        end else if (state_d == ST_WRITE) begin
            mem_addr_d  = addr_q;
            mem_wdata_d = {96'd0, wdata_q};
        end else begin
            // Hold the last address/data so the bus never toggles needlessly.
            mem_addr_d  = mem_addr_q;
            mem_wdata_d = mem_wdata_q;
        end
    end

    // State, request latch, line array and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            addr_q       <= 10'd0;
            wdata_q      <= 32'd0;
            lat_q        <= {LAT_W{1'b0}};
            valid_q      <= {NUM_LINES{1'b0}};
            for (int i = 0; i < NUM_LINES; i++) begin
                tag_q[i]  <= {TAG_W{1'b0}};
                data_q[i] <= 128'd0;
            end
            cpu_rdata_q  <= 32'd0;
            cpu_ready_q  <= 1'b0;
            cpu_hit_q    <= 1'b0;
            mem_read_q   <= 1'b1;
            mem_lock_q   <= 1'b1;
            mem_addr_q   <= 10'd0;
            mem_wdata_q  <= 128'd0;
            hit_count_q  <= {CNT_W{1'b0}};
            miss_count_q <= {CNT_W{1'b0}};
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_q        <= lat_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_hit_q    <= cpu_hit_d;
            mem_read_q   <= mem_read_d;
            mem_lock_q   <= mem_lock_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_cache_ctrl
// Table-driven bench for dm_cache_ctrl with a word-addressed memory model.
// Cycle 1 is the cycle right after the edge that accepts a request.
// -----------------------------------------------------------------------------
module tb_dm_cache_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    dm_cache_ctrl_if #(.CNT_W(16)) bus ();

    dm_cache_ctrl #(
        .NUM_LINES   (4),
        .MEM_LATENCY (4),
        .CNT_W       (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: reloaded during reset, written through when isLock=0 and isMemRead=0
    logic [31:0] mem [1024];
    logic [9:0]  mem_base;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
            mem[0]   <= 32'h0000_3CC3;
            mem[2]   <= 32'h0000_2222;
            mem[768] <= 32'h0000_00C3;
        end else if (!bus.mem_lock && !bus.mem_read) begin
            mem[bus.mem_addr] <= bus.mem_wdata[31:0];
        end
    end

    always_comb begin
        mem_base = {bus.mem_addr[9:2], 2'b00};
        bus.mem_rdata = {mem[mem_base], mem[mem_base + 10'd1],
                         mem[mem_base + 10'd2], mem[mem_base + 10'd3]};
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one request and observe it until cpu_ready (bounded).
    task automatic run_req(input  logic        we,
                           input  logic [9:0]  addr,
                           input  logic [31:0] wd,
                           output int          lat,
                           output logic        hit,
                           output logic [31:0] rd,
                           output int          lock_cyc,
                           output int          wr_cyc,
                           output int          bad_cyc,
                           output logic        pulse_ok);
        logic [9:0] exp_ma;
        exp_ma   = we ? addr : {addr[9:2], 2'b00};
        lat      = -1;
        hit      = 1'b0;
        rd       = 32'd0;
        lock_cyc = 0;
        wr_cyc   = 0;
        bad_cyc  = 0;
        pulse_ok = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            if (bus.mem_lock === 1'b0) begin
                lock_cyc++;
                if (bus.mem_addr !== exp_ma) bad_cyc++;
                if (bus.mem_read === 1'b0) begin
                    wr_cyc++;
                    if (bus.mem_wdata !== {96'd0, wd}) bad_cyc++;
                end
            end
            if (bus.cpu_ready === 1'b1) begin
                lat = c;
                hit = bus.cpu_hit;
                rd  = bus.cpu_rdata;
                break;
            end
        end
        if (lat > 0) begin
            @(posedge clk);
            #1;
            pulse_ok = (bus.cpu_ready === 1'b0);
        end
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic        hit;
        logic [31:0] rdata;
        int          hits;
        int          misses;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic        hit;
        logic [31:0] rd;
        int          lock_cyc;
        int          wr_cyc;
        int          bad_cyc;
        logic        pulse_ok;

        total = 0;
        bad   = 0;

        //            we    addr     wdata          lat hit   rdata          h  m
        vecs[0]  = '{1'b0, 10'd0,   32'd0,          6, 1'b0, 32'h0000_3CC3, 0, 1};
        vecs[1]  = '{1'b0, 10'd0,   32'd0,          2, 1'b1, 32'h0000_3CC3, 1, 1};
        vecs[2]  = '{1'b0, 10'd768, 32'd0,          6, 1'b0, 32'h0000_00C3, 1, 2};
        vecs[3]  = '{1'b0, 10'd0,   32'd0,          6, 1'b0, 32'h0000_3CC3, 1, 3};
        vecs[4]  = '{1'b1, 10'd1,   32'hDEAD_BEEF,  6, 1'b1, 32'd0,         2, 3};
        vecs[5]  = '{1'b0, 10'd1,   32'd0,          2, 1'b1, 32'hDEAD_BEEF, 3, 3};
        vecs[6]  = '{1'b0, 10'd2,   32'd0,          2, 1'b1, 32'h0000_2222, 4, 3};
        vecs[7]  = '{1'b1, 10'd5,   32'h1234_5678,  6, 1'b0, 32'd0,         4, 4};
        vecs[8]  = '{1'b0, 10'd5,   32'd0,          6, 1'b0, 32'h1234_5678, 4, 5};
        vecs[9]  = '{1'b0, 10'd5,   32'd0,          2, 1'b1, 32'h1234_5678, 5, 5};
        vecs[10] = '{1'b1, 10'd768, 32'hAAAA_5555,  6, 1'b0, 32'd0,         5, 6};
        vecs[11] = '{1'b0, 10'd1,   32'd0,          2, 1'b1, 32'hDEAD_BEEF, 6, 6};
        vecs[12] = '{1'b0, 10'd768, 32'd0,          6, 1'b0, 32'hAAAA_5555, 6, 7};

        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 10'd0;
        bus.cpu_wdata = 32'd0;
        rst_n         = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_lock",  bus.mem_lock,   1);
        chk("rst_mem_read",  bus.mem_read,   1);
        chk("rst_cpu_ready", bus.cpu_ready,  0);
        chk("rst_cpu_rdata", bus.cpu_rdata,  0);
        chk("rst_mem_addr",  bus.mem_addr,   0);
        chk("rst_hits",      bus.hit_count,  0);
        chk("rst_misses",    bus.miss_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single requests
        for (int i = 0; i < 13; i++) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, hit, rd, lock_cyc, wr_cyc, bad_cyc, pulse_ok);
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_hit", i), hit, vecs[i].hit);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_hits", i), bus.hit_count, vecs[i].hits);
            chk($sformatf("v%0d_misses", i), bus.miss_count, vecs[i].misses);
            chk($sformatf("v%0d_lock_cycles", i), lock_cyc, (vecs[i].lat == 2) ? 0 : 4);
            chk($sformatf("v%0d_write_cycles", i), wr_cyc, vecs[i].we ? 4 : 0);
            chk($sformatf("v%0d_bus_values", i), bad_cyc, 0);
            chk($sformatf("v%0d_ready_pulse", i), pulse_ok, 1);
        end

        // Reset during the second FILL cycle
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'd0;
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("midfill_lock_low", bus.mem_lock, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midfill_lock_now", bus.mem_lock,   1);
        chk("midfill_read_now", bus.mem_read,   1);
        chk("midfill_misses",   bus.miss_count, 0);
        lat = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.cpu_ready !== 1'b0) lat++;
        end
        chk("midfill_no_ready", lat, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_req(1'b0, 10'd0, 32'd0, lat, hit, rd, lock_cyc, wr_cyc, bad_cyc, pulse_ok);
        chk("post_rst_latency", lat, 6);
        chk("post_rst_hit",     hit, 0);
        chk("post_rst_rdata",   rd, 32'h0000_3CC3);
        chk("post_rst_misses",  bus.miss_count, 1);
        chk("post_rst_hits",    bus.hit_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
